// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package mips_fetch_pkg;

  localparam int unsigned WordW = 32;
  localparam logic [WordW-1:0] ResetVector = 32'hBFC0_0000;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StHave,
    StDiscard,
    StErr
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding imem read, buffered word to IF/ID.
// Optional ack-wait timeout enabled by defining FETCH_TIMEOUT_EN.
module if_fetch_ctrl
  import mips_fetch_pkg::*;
#(
  parameter logic [WordW-1:0] RESET_VECTOR   = ResetVector,
  parameter int unsigned      TIMEOUT_CYCLES = 256
) (
  input  logic             clock,
  input  logic             reset,
  output logic             imem_req,
  output logic [WordW-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WordW-1:0] imem_rdata,
  input  logic             id_stall,
  input  logic             br_taken,
  input  logic [WordW-1:0] br_target,
  input  logic             exc_flush,
  input  logic [WordW-1:0] exc_target,
  output logic [WordW-1:0] if_instruction,
  output logic [WordW-1:0] if_pc,
  output logic [WordW-1:0] if_pc_add4,
  output logic             if_is_bds,
  output logic             if_stall,
  output logic             if_flush,
  output logic             fetch_bus_err
);

  fetch_state_t     state_q, state_d;
  logic [WordW-1:0] pc_q, pc_d;
  logic [WordW-1:0] addr_q, addr_d;
  logic [WordW-1:0] instr_q, instr_d;
  logic [WordW-1:0] tgt_q, tgt_d;
  logic             bp_q, bp_d;
  logic             fp_q, fp_d;
  logic [WordW-1:0] next_pc;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            timeout;
  assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    if (br_taken) begin
      next_pc = br_target;
    end else if (bp_q) begin
      next_pc = tgt_q;
    end else begin
      next_pc = pc_q + 32'd4;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    tgt_d   = tgt_q;
    bp_d    = bp_q;
    fp_d    = fp_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q + CntW'(1);
    err_d   = 1'b0;
`endif

    if (exc_flush) begin
      fp_d = 1'b1;
    end else if (!id_stall) begin
      fp_d = 1'b0;
    end

    // Redirect beats a same-cycle branch: the branch itself is being squashed.
    if (exc_flush) begin
      pc_d = exc_target;
      bp_d = 1'b0;
    end else if (br_taken) begin
      tgt_d = br_target;
      bp_d  = 1'b1;
    end

    unique case (state_q)
      StIdle, StErr: begin
        if (exc_flush) begin
          state_d = StReq;
          addr_d  = exc_target;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (state_q == StIdle) begin
          state_d = StReq;
          addr_d  = pc_q;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StReq: begin
        if (exc_flush) begin
          if (imem_ack) begin
            state_d = StReq;
            addr_d  = exc_target;
          end else begin
            state_d = StDiscard;
          end
`ifdef FETCH_TIMEOUT_EN
          cnt_d = '0;
`endif
        end else if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StHave;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (timeout) begin
          state_d = StErr;
          err_d   = 1'b1;
        end
`endif
      end
      StHave: begin
        if (exc_flush) begin
          state_d = StReq;
          addr_d  = exc_target;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (!id_stall) begin
          pc_d    = next_pc;
          addr_d  = next_pc;
          bp_d    = 1'b0;
          state_d = StReq;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StDiscard: begin
        // Stale read still owns the bus; address must not move until it returns.
        if (imem_ack) begin
          state_d = StReq;
          addr_d  = exc_flush ? exc_target : pc_q;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
`ifdef FETCH_TIMEOUT_EN
        else if (timeout) begin
          state_d = StErr;
          err_d   = 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_VECTOR;
      addr_q  <= RESET_VECTOR;
      instr_q <= '0;
      tgt_q   <= '0;
      bp_q    <= 1'b0;
      fp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      tgt_q   <= tgt_d;
      bp_q    <= bp_d;
      fp_q    <= fp_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign fetch_bus_err = err_q;
`else
  assign fetch_bus_err = 1'b0;
`endif

  assign imem_req       = (state_q == StReq) || (state_q == StDiscard);
  assign imem_addr      = addr_q;
  assign if_instruction = instr_q;
  assign if_pc          = pc_q;
  assign if_pc_add4     = pc_q + 32'd4;
  assign if_is_bds      = bp_q;
  assign if_stall       = (state_q != StHave);
  assign if_flush       = fp_q | exc_flush;

endmodule
